// File: rtl/kart_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : kart_state_tx
// Description : RMII Ethernet transmitter for the opponent-state link. On each
//               accepted request it latches the local kart state and sends one
//               fixed-length Ethernet II frame: preamble/SFD, header, 6-byte
//               payload, 40 bytes of zero pad and the CRC-32 FCS. Every frame
//               is followed by an inter-frame gap.
// Ports       : clk_in          - 50 MHz RMII reference clock
//               rst_in          - synchronous active-high reset
//               send_in         - frame request, accepted when ready_out=1
//               player_x/y      - kart position (11 bits each)
//               direction       - heading in degrees (9 bits)
//               game_stat       - game status code (3 bits)
//               reset_req       - opponent-reset flag
//               ready_out       - high only while idle
//               eth_txen/txd    - RMII transmit enable / dibit
//               frames_sent_out - completed-frame counter (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module kart_state_tx #(
    parameter logic [47:0] DEST_MAC   = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE  = 16'h88B5,
    parameter int          IFG_CYCLES = 48
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        send_in,
    input  logic [10:0] player_x,
    input  logic [10:0] player_y,
    input  logic [8:0]  direction,
    input  logic [2:0]  game_stat,
    input  logic        reset_req,
    output logic        ready_out,
    output logic        eth_txen,
    output logic [1:0]  eth_txd,
    output logic [15:0] frames_sent_out
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREAMBLE = 3'd1;
    localparam logic [2:0] S_HEADER   = 3'd2;
    localparam logic [2:0] S_PAYLOAD  = 3'd3;
    localparam logic [2:0] S_PAD      = 3'd4;
    localparam logic [2:0] S_FCS      = 3'd5;
    localparam logic [2:0] S_IFG      = 3'd6;

    // Index of the last byte in each transmitting section
    localparam logic [5:0] PRE_LAST = 6'd7;
    localparam logic [5:0] HDR_LAST = 6'd13;
    localparam logic [5:0] PAY_LAST = 6'd5;
    localparam logic [5:0] PAD_LAST = 6'd39;
    localparam logic [5:0] FCS_LAST = 6'd3;

    localparam int IFG_W = (IFG_CYCLES > 2) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LAST = IFG_W'(IFG_CYCLES - 1);

    localparam logic [111:0] HDR_BYTES = {DEST_MAC, SRC_MAC, ETHERTYPE};
    localparam logic [31:0]  CRC_POLY  = 32'hEDB88320;
    localparam logic [31:0]  CRC_INIT  = 32'hFFFFFFFF;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]       state_q,   state_d;
    logic [5:0]       byte_q,    byte_d;
    logic [1:0]       dibit_q,   dibit_d;
    logic [IFG_W-1:0] ifg_q,     ifg_d;
    logic [47:0]      payload_q, payload_d;
    logic [31:0]      crc_q,     crc_d;
    logic [15:0]      frames_q,  frames_d;

    // Reflected CRC-32 advanced by one dibit, bit [0] first (wire order)
    function automatic logic [31:0] crc_dibit(input logic [31:0] crc,
                                              input logic [1:0]  d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // ------------------------------------------------------------------------
    // Byte / dibit selection for the current position in the frame
    // ------------------------------------------------------------------------
    logic [7:0]  cur_byte;
    logic [1:0]  cur_dibit;
    logic [5:0]  last_idx;
    logic [31:0] fcs_word;
    logic        tx_active;
    logic        sect_end;
    logic        accept;

    assign fcs_word  = ~crc_q;
    assign tx_active = (state_q == S_PREAMBLE) || (state_q == S_HEADER) ||
                       (state_q == S_PAYLOAD)  || (state_q == S_PAD)    ||
                       (state_q == S_FCS);
    assign accept    = (state_q == S_IDLE) && send_in;

    always_comb begin
        cur_byte = 8'h00;
        last_idx = 6'd0;
        case (state_q)
            S_PREAMBLE: begin
                cur_byte = (byte_q == PRE_LAST) ? 8'hD5 : 8'h55;
                last_idx = PRE_LAST;
            end
            S_HEADER: begin
                // MSB byte of the header goes out first
                cur_byte = HDR_BYTES[(13 - int'(byte_q)) * 8 +: 8];
                last_idx = HDR_LAST;
            end
            S_PAYLOAD: begin
                cur_byte = payload_q[(5 - int'(byte_q)) * 8 +: 8];
                last_idx = PAY_LAST;
            end
            S_PAD: begin
                cur_byte = 8'h00;
                last_idx = PAD_LAST;
            end
            S_FCS: begin
                // FCS goes out least significant byte first
                cur_byte = fcs_word[int'(byte_q) * 8 +: 8];
                last_idx = FCS_LAST;
            end
            default: begin
                cur_byte = 8'h00;
                last_idx = 6'd0;
            end
        endcase
    end

    always_comb begin
        case (dibit_q)
            2'd0:    cur_dibit = cur_byte[1:0];
            2'd1:    cur_dibit = cur_byte[3:2];
            2'd2:    cur_dibit = cur_byte[5:4];
            default: cur_dibit = cur_byte[7:6];
        endcase
    end

    assign sect_end = (dibit_q == 2'd3) && (byte_q == last_idx);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        dibit_d   = dibit_q;
        ifg_d     = ifg_q;
        payload_d = payload_q;
        crc_d     = crc_q;
        frames_d  = frames_q;

        if (tx_active) begin
            dibit_d = dibit_q + 2'd1;
            if (dibit_q == 2'd3) begin
                byte_d = byte_q + 6'd1;
            end
            if (sect_end) begin
                byte_d = 6'd0;
            end
        end

        // The CRC covers header, payload and pad; it is frozen while the
        // FCS itself is being shifted out.
        if ((state_q == S_HEADER) || (state_q == S_PAYLOAD) ||
            (state_q == S_PAD)) begin
            crc_d = crc_dibit(crc_q, cur_dibit);
        end

        case (state_q)
            S_IDLE: begin
                byte_d  = 6'd0;
                dibit_d = 2'd0;
                ifg_d   = '0;
                if (accept) begin
                    state_d   = S_PREAMBLE;
                    crc_d     = CRC_INIT;
                    payload_d = {4'b0, player_x, 1'b0, player_y, 1'b0,
                                 direction, 3'b0, game_stat, 1'b0,
                                 reset_req, 3'b0};
                end
            end
            S_PREAMBLE: if (sect_end) state_d = S_HEADER;
            S_HEADER:   if (sect_end) state_d = S_PAYLOAD;
            S_PAYLOAD:  if (sect_end) state_d = S_PAD;
            S_PAD:      if (sect_end) state_d = S_FCS;
            S_FCS: begin
                if (sect_end) begin
                    state_d  = S_IFG;
                    ifg_d    = '0;
                    frames_d = frames_q + 16'd1;
                end
            end
            S_IFG: begin
                ifg_d = ifg_q + 1'b1;
                if (ifg_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    ifg_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= S_IDLE;
            byte_q    <= 6'd0;
            dibit_q   <= 2'd0;
            ifg_q     <= '0;
            payload_q <= 48'd0;
            crc_q     <= CRC_INIT;
            frames_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            byte_q    <= byte_d;
            dibit_q   <= dibit_d;
            ifg_q     <= ifg_d;
            payload_q <= payload_d;
            crc_q     <= crc_d;
            frames_q  <= frames_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs (decoded from registered state only)
    // ------------------------------------------------------------------------
    assign ready_out       = (state_q == S_IDLE);
    assign eth_txen        = tx_active;
    assign eth_txd         = tx_active ? cur_dibit : 2'b00;
    assign frames_sent_out = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_kart_state_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_kart_state_tx
// Description : Self-checking bench for kart_state_tx. Captures the RMII
//               stream cycle by cycle after each accept and compares it with
//               hand-computed frame contents and a software CRC-32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kart_state_tx;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        send_in = 1'b0;
    logic [10:0] player_x = '0;
    logic [10:0] player_y = '0;
    logic [8:0]  direction = '0;
    logic [2:0]  game_stat = '0;
    logic        reset_req = 1'b0;
    logic        ready_out;
    logic        eth_txen;
    logic [1:0]  eth_txd;
    logic [15:0] frames_sent_out;

    int errors = 0;
    int checks = 0;

    localparam int NREC = 340;
    logic       en_a  [0:NREC];
    logic [1:0] d_a   [0:NREC];
    logic       rdy_a [0:NREC];
    logic [7:0] cap   [0:71];
    int         txd_bad;

    kart_state_tx dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .send_in         (send_in),
        .player_x        (player_x),
        .player_y        (player_y),
        .direction       (direction),
        .game_stat       (game_stat),
        .reset_req       (reset_req),
        .ready_out       (ready_out),
        .eth_txen        (eth_txen),
        .eth_txd         (eth_txd),
        .frames_sent_out (frames_sent_out)
    );

    always #5 clk_in = ~clk_in;

    // Bytewise reflected CRC-32 reference
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in,
                                             input logic [7:0]  b);
        logic [31:0] c;
        c = c_in;
        for (int k = 0; k < 8; k++) begin
            if (c[0] ^ b[k]) c = (c >> 1) ^ 32'hEDB88320;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // Expected frame byte i (0 = first preamble byte), excluding the FCS
    function automatic logic [7:0] exp_byte(input int i, input logic [7:0] p5);
        if (i < 7)       return 8'h55;
        else if (i == 7) return 8'hD5;
        else if (i < 14) return 8'hFF;
        else if (i == 14) return 8'h02;
        else if (i < 19) return 8'h00;
        else if (i == 19) return 8'h01;
        else if (i == 20) return 8'h88;
        else if (i == 21) return 8'hB5;
        else if (i == 22) return 8'h01;
        else if (i == 23) return 8'h7E;
        else if (i == 24) return 8'h17;
        else if (i == 25) return 8'hE8;
        else if (i == 26) return 8'h70;
        else if (i == 27) return p5;
        else             return 8'h00;
    endfunction

    task automatic start_frame(input logic [10:0] x, input logic [10:0] y,
                               input logic [8:0] d, input logic [2:0] g,
                               input logic r);
        @(negedge clk_in);
        player_x  = x;
        player_y  = y;
        direction = d;
        game_stat = g;
        reset_req = r;
        send_in   = 1'b1;
        @(posedge clk_in);
    endtask

    // Record cycles 1..n after an accept edge; busy=1 adds stray requests at
    // cycles 10 and 300 and changes player_x at cycle 50.
    task automatic record(input int n, input bit busy);
        txd_bad = 0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk_in);
            en_a[c]  = eth_txen;
            d_a[c]   = eth_txd;
            rdy_a[c] = ready_out;
            if (!eth_txen && eth_txd !== 2'b00) txd_bad++;
            send_in = 1'b0;
            if (busy && (c == 10 || c == 300)) send_in = 1'b1;
            if (busy && c == 50) player_x = 11'd5;
        end
        send_in = 1'b0;
    endtask

    task automatic decode();
        for (int b = 0; b < 72; b++) begin
            cap[b] = {d_a[4*b+4], d_a[4*b+3], d_a[4*b+2], d_a[4*b+1]};
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        checks++; if (eth_txen !== 1'b0) begin errors++; $display("FAIL reset_txen: got %b want 0", eth_txen); end
        checks++; if (eth_txd !== 2'b00) begin errors++; $display("FAIL reset_txd: got %b want 00", eth_txd); end
        checks++; if (frames_sent_out !== 16'd0) begin errors++; $display("FAIL reset_frames: got %0d want 0", frames_sent_out); end
    endtask

    task automatic test_single_frame();
        int n_en;
        logic [31:0] crc;
        logic [31:0] fcs;
        start_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        record(NREC, 1'b0);
        decode();
        n_en = 0;
        for (int c = 1; c <= NREC; c++) if (en_a[c]) n_en++;
        checks++; if (n_en !== 288) begin errors++; $display("FAIL txen_len: got %0d want 288", n_en); end
        checks++; if (en_a[1] !== 1'b1 || en_a[288] !== 1'b1 || en_a[289] !== 1'b0)
            begin errors++; $display("FAIL txen_window: got c1=%b c288=%b c289=%b want 1 1 0", en_a[1], en_a[288], en_a[289]); end
        checks++; if (txd_bad !== 0) begin errors++; $display("FAIL txd_idle_zero: got %0d bad cycles want 0", txd_bad); end
        for (int b = 0; b < 68; b++) begin
            checks++;
            if (cap[b] !== exp_byte(b, 8'h20)) begin
                errors++; $display("FAIL frame_byte%0d: got %h want %h", b, cap[b], exp_byte(b, 8'h20));
            end
        end
        // First payload byte 0x01 starts at cycle 1 + 22*4
        checks++; if ({d_a[89], d_a[90], d_a[91], d_a[92]} !== 8'b01_00_00_00)
            begin errors++; $display("FAIL payload0_dibits: got %b %b %b %b want 01 00 00 00", d_a[89], d_a[90], d_a[91], d_a[92]); end
        crc = 32'hFFFFFFFF;
        for (int b = 8; b < 68; b++) crc = crc_byte(crc, exp_byte(b, 8'h20));
        fcs = ~crc;
        checks++; if ({cap[71], cap[70], cap[69], cap[68]} !== fcs)
            begin errors++; $display("FAIL fcs: got %h want %h", {cap[71], cap[70], cap[69], cap[68]}, fcs); end
        crc = 32'hFFFFFFFF;
        for (int b = 8; b < 72; b++) crc = crc_byte(crc, cap[b]);
        checks++; if (crc !== 32'hDEBB20E3) begin errors++; $display("FAIL crc_residue: got %h want DEBB20E3", crc); end
        checks++; if (rdy_a[336] !== 1'b0 || rdy_a[337] !== 1'b1)
            begin errors++; $display("FAIL ready_return: got c336=%b c337=%b want 0 1", rdy_a[336], rdy_a[337]); end
        checks++; if (frames_sent_out !== 16'd1) begin errors++; $display("FAIL frames_one: got %0d want 1", frames_sent_out); end
    endtask

    task automatic test_fcs_reset_flag();
        logic [31:0] crc;
        start_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b1);
        record(NREC, 1'b0);
        decode();
        checks++; if (cap[27] !== 8'h28) begin errors++; $display("FAIL rflag_payload5: got %h want 28", cap[27]); end
        checks++; if (cap[26] !== 8'h70) begin errors++; $display("FAIL rflag_payload4: got %h want 70", cap[26]); end
        crc = 32'hFFFFFFFF;
        for (int b = 8; b < 68; b++) crc = crc_byte(crc, exp_byte(b, 8'h28));
        checks++; if ({cap[71], cap[70], cap[69], cap[68]} !== ~crc)
            begin errors++; $display("FAIL rflag_fcs: got %h want %h", {cap[71], cap[70], cap[69], cap[68]}, ~crc); end
        checks++; if (frames_sent_out !== 16'd2) begin errors++; $display("FAIL rflag_frames: got %0d want 2", frames_sent_out); end
    endtask

    task automatic test_busy_hold();
        int n_en;
        int rdy_hi;
        logic [15:0] f0;
        f0 = frames_sent_out;
        start_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        record(NREC, 1'b1);
        decode();
        n_en = 0;
        rdy_hi = 0;
        for (int c = 1; c <= NREC; c++) if (en_a[c]) n_en++;
        for (int c = 1; c <= 336; c++) if (rdy_a[c]) rdy_hi++;
        checks++; if (n_en !== 288) begin errors++; $display("FAIL busy_one_frame: got %0d txen cycles want 288", n_en); end
        checks++; if (rdy_hi !== 0) begin errors++; $display("FAIL busy_ready_low: got %0d high cycles want 0", rdy_hi); end
        checks++; if (rdy_a[337] !== 1'b1) begin errors++; $display("FAIL busy_ready_337: got %b want 1", rdy_a[337]); end
        checks++; if (en_a[338] !== 1'b0) begin errors++; $display("FAIL busy_no_queue: got txen=%b want 0", en_a[338]); end
        checks++; if ({cap[22], cap[23]} !== 16'h017E) begin errors++; $display("FAIL busy_payload_hold: got %h want 017E", {cap[22], cap[23]}); end
        checks++; if (frames_sent_out !== f0 + 16'd1) begin errors++; $display("FAIL busy_frames: got %0d want %0d", frames_sent_out, f0 + 16'd1); end
        player_x = 11'd191;
    endtask

    task automatic test_back_to_back();
        int rise [0:3];
        logic [15:0] frm [0:3];
        int nr;
        int ifg_cnt;
        logic prev;
        bit done;
        nr = 0;
        ifg_cnt = 0;
        prev = 1'b0;
        @(negedge clk_in);
        send_in = 1'b1;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk_in);
            if (eth_txen && !prev && nr < 4) begin
                rise[nr] = c;
                frm[nr] = frames_sent_out;
                nr++;
            end
            if (nr == 1 && !eth_txen && !ready_out) ifg_cnt++;
            prev = eth_txen;
        end
        send_in = 1'b0;
        checks++; if (nr < 3) begin errors++; $display("FAIL b2b_starts: got %0d frame starts want >=3", nr); end
        if (nr >= 3) begin
            checks++; if (rise[1] - rise[0] !== 337) begin errors++; $display("FAIL b2b_period1: got %0d want 337", rise[1] - rise[0]); end
            checks++; if (rise[2] - rise[1] !== 337) begin errors++; $display("FAIL b2b_period2: got %0d want 337", rise[2] - rise[1]); end
            checks++; if (frm[1] - frm[0] !== 16'd1) begin errors++; $display("FAIL b2b_count: got %0d want 1", frm[1] - frm[0]); end
        end
        checks++; if (ifg_cnt !== 48) begin errors++; $display("FAIL b2b_ifg: got %0d want 48", ifg_cnt); end
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk_in);
            if (ready_out) done = 1'b1;
        end
        checks++; if (!done) begin errors++; $display("FAIL b2b_drain: got ready=0 want 1 within 400 cycles"); end
    endtask

    task automatic test_reset_mid_frame();
        int n_en;
        logic [31:0] crc;
        start_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b0);
        record(99, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        checks++; if (eth_txen !== 1'b0) begin errors++; $display("FAIL rstmid_txen: got %b want 0", eth_txen); end
        checks++; if (eth_txd !== 2'b00) begin errors++; $display("FAIL rstmid_txd: got %b want 00", eth_txd); end
        checks++; if (ready_out !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b want 1", ready_out); end
        checks++; if (frames_sent_out !== 16'd0) begin errors++; $display("FAIL rstmid_frames: got %0d want 0", frames_sent_out); end
        rst_in = 1'b0;
        start_frame(11'd191, 11'd191, 9'd270, 3'd1, 1'b1);
        record(NREC, 1'b0);
        decode();
        n_en = 0;
        for (int c = 1; c <= NREC; c++) if (en_a[c]) n_en++;
        checks++; if (n_en !== 288) begin errors++; $display("FAIL rstmid_len: got %0d want 288", n_en); end
        checks++; if (cap[7] !== 8'hD5 || cap[27] !== 8'h28)
            begin errors++; $display("FAIL rstmid_content: got sfd=%h p5=%h want D5 28", cap[7], cap[27]); end
        crc = 32'hFFFFFFFF;
        for (int b = 8; b < 72; b++) crc = crc_byte(crc, cap[b]);
        checks++; if (crc !== 32'hDEBB20E3) begin errors++; $display("FAIL rstmid_residue: got %h want DEBB20E3", crc); end
        checks++; if (frames_sent_out !== 16'd1) begin errors++; $display("FAIL rstmid_frames_after: got %0d want 1", frames_sent_out); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_fcs_reset_flag();
        test_busy_hold();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kart_state_tx.md
Name: kart_state_tx

Overview:
- RMII Ethernet transmitter that packs the local player's kart state into one fixed-length Ethernet II frame per request. Drives eth_txd and eth_txen.
- The 44-bit state word uses exactly the bit layout the receive path unpacks: x[43:33], y[31:21], dir[19:11], game[7:5], reset[3]. All other bits are 0.
- Sits in the eth_refclk (50 MHz) domain, between game logic and the PHY. It is the sending end of the opponent-state link.

Parameters:
- DEST_MAC, 48'hFF_FF_FF_FF_FF_FF, destination MAC address.
- SRC_MAC, 48'h02_00_00_00_00_01, source MAC address.
- ETHERTYPE, 16'h88B5, EtherType field value.
- IFG_CYCLES, 48, idle dibit cycles after each frame (12 bytes).

Ports:
- clk_in  input  1  50 MHz RMII reference clock.
- rst_in  input  1  synchronous active-high reset.
- send_in  input  1  request a frame; accepted only when ready_out=1.
- player_x  input  11  player x position.
- player_y  input  11  player y position.
- direction  input  9  heading in degrees.
- game_stat  input  3  game status code.
- reset_req  input  1  opponent-reset flag.
- ready_out  output  1  high only in IDLE.
- eth_txen  output  1  RMII transmit enable.
- eth_txd  output  2  RMII transmit dibit.
- frames_sent_out  output  16  count of completed frames; wraps at 65535->0.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE; ready_out=1; eth_txen=0; eth_txd=0; frames_sent_out=0.
  - If rst_in rises mid-frame, eth_txen drops on the next edge, the frame is truncated, and no IFG is inserted.
  - frames_sent_out is cleared.
- Handshake:
  - Accept occurs on the edge where send_in=1 and ready_out=1.
  - All state inputs are latched on that edge. Input changes after the accept do not affect the frame in flight.
  - send_in while busy is ignored. It is not queued.
- Payload word: P[47:0] = {4'b0, x, 1'b0, y, 1'b0, dir, 3'b0, game, 1'b0, reset, 3'b0}.
- Byte order:
  - Frame bytes after the SFD, in order: DEST_MAC (MSB byte first), SRC_MAC (MSB byte first), ETHERTYPE (high byte first).
  - Then payload P[47:40], P[39:32], P[31:24], P[23:16], P[15:8], P[7:0].
  - Then 40 bytes of 0x00 pad, then the 4-byte FCS.
- Dibit order: each byte is sent LSB dibit first: [1:0], [3:2], [5:4], [7:6].
- State machine:
  - IDLE -> PREAMBLE on accept.
  - PREAMBLE: 7 bytes of 0x55 then 1 byte of 0xD5 (32 cycles) -> HEADER.
  - HEADER: 14 bytes (56 cycles) -> PAYLOAD.
  - PAYLOAD: 6 bytes (24 cycles) -> PAD.
  - PAD: 40 bytes (160 cycles) -> FCS.
  - FCS: 4 bytes (16 cycles) -> IFG.
  - IFG: IFG_CYCLES cycles with eth_txen=0 and eth_txd=0 -> IDLE.
  - frames_sent_out increments on the FCS->IFG edge.
- Timing, with the accept at edge 0:
  - eth_txen is high for cycles 1..288 inclusive (72 bytes), carrying the first preamble dibit at cycle 1.
  - IFG covers cycles 289..336.
  - ready_out returns high at cycle 337.
  - Whenever eth_txen=0, eth_txd=0.
- CRC-32 (IEEE 802.3):
  - Reflected polynomial 0xEDB88320, init 0xFFFFFFFF.
  - Computed over the header, payload and pad bytes (60 bytes). Preamble and SFD are excluded.
  - Update is 2 bits per cycle, in dibit transmission order.
  - FCS = ~crc, sent bits [7:0] first, then [15:8], [23:16], [31:24], each byte LSB dibit first.
- Byte and dibit counters are internal and reset to 0 on every state entry. There are no gaps or stalls inside a frame.

Test Plan:
- Idle after reset:
  - Stimulus: assert rst_in for 5 cycles, then release.
  - Required: ready_out=1, eth_txen=0, eth_txd=0, frames_sent_out=0.
- Single frame:
  - Stimulus: x=191, y=191, dir=270, game=1, reset_req=0; pulse send_in.
  - Required: eth_txen is high exactly 288 cycles; the first 32 dibits are 28×2'b01 followed by 01,01,01,11; payload bytes are 01 7E 17 E8 70 20, with byte 0x01 sent as dibits 01,00,00,00; frames_sent_out=1.
- FCS check:
  - Stimulus: capture the single frame above and run it through a software CRC-32 model.
  - Required: the residue over header+payload+pad+FCS equals 0xDEBB20E3. Separately, setting reset_req=1 changes only payload byte 5 to 0x28 and produces a matching FCS.
- Busy and input hold:
  - Stimulus: pulse send_in at cycles 10 and 300 after an accept, and change player_x mid-frame.
  - Required: only one frame is sent, its payload is unchanged by the player_x change, and ready_out stays low until cycle 337.
- Back-to-back frames:
  - Stimulus: hold send_in=1 continuously.
  - Required: frames start every 337 cycles with exactly 48 low cycles between frames. After 65536 frames, frames_sent_out wraps to 0.
- Reset mid-frame:
  - Stimulus: assert rst_in at cycle 100 of a frame.
  - Required: eth_txen=0 from the next edge, ready_out=1, and a new send_in produces a complete, correct frame.
